// File: rtl/soc_rst_pkg.sv
// Shared state encoding, reset-cause bit positions and sizing helper for the SoC reset sequencer.
package soc_rst_pkg;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_state_e;

    localparam int CAUSE_W    = 5;
    localparam int CAUSE_POR  = 0;
    localparam int CAUSE_EXT  = 1;
    localparam int CAUSE_LOCK = 2;
    localparam int CAUSE_SW   = 3;
    localparam int CAUSE_WDT  = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_RST_VAL = 5'b00001;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/soc_reset_sequencer_if.sv
// Request/status bundle between the SoC reset sequencer and its surroundings.
// Watchdog controls are present only when SOC_RST_WDT_EN is defined.
interface soc_reset_sequencer_if #(
    parameter int N_DOM = 3
);
    logic                            ext_rst_req;
    logic                            sw_rst_req;
    logic                            pll_locked;
    logic                            cause_clr;
    logic [N_DOM-1:0]                rst_out;
    logic                            seq_done;
    logic [soc_rst_pkg::CAUSE_W-1:0] rst_cause;

`ifdef SOC_RST_WDT_EN
    logic wdt_arm;
    logic wdt_kick;

    modport master (
        output ext_rst_req, sw_rst_req, pll_locked, cause_clr, wdt_arm, wdt_kick,
        input  rst_out, seq_done, rst_cause
    );
    modport slave (
        input  ext_rst_req, sw_rst_req, pll_locked, cause_clr, wdt_arm, wdt_kick,
        output rst_out, seq_done, rst_cause
    );
`else
    modport master (
        output ext_rst_req, sw_rst_req, pll_locked, cause_clr,
        input  rst_out, seq_done, rst_cause
    );
    modport slave (
        input  ext_rst_req, sw_rst_req, pll_locked, cause_clr,
        output rst_out, seq_done, rst_cause
    );
`endif
endinterface

// File: rtl/soc_rst_lock_filter.sv
// Counts consecutive pll_locked=1 cycles; done marks the cycle completing LOCK_FILT in a row.
module soc_rst_lock_filter #(
    parameter int LOCK_FILT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic pll_locked,
    output logic done
);
    localparam int CNT_W = $clog2(LOCK_FILT + 1);

    logic [CNT_W-1:0] cnt;

    assign done = pll_locked && (cnt == CNT_W'(LOCK_FILT - 1));

    // Any low sample restarts the run; the count saturates once done.
    always_ff @(posedge clk) begin
        if (rst || clr || !pll_locked) begin
            cnt <= '0;
        end else if (!done) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/soc_reset_sequencer.sv
// SoC reset sequencer: reset stretch, filtered PLL lock, staggered domain release, cause capture.
// Optional watchdog reset source is built when SOC_RST_WDT_EN is defined.
module soc_reset_sequencer
    import soc_rst_pkg::*;
#(
    parameter int N_DOM       = 3,
    parameter int STRETCH_CYC = 16,
    parameter int LOCK_FILT   = 4,
    parameter int STEP_CYC    = 8,
    parameter int WDT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    soc_reset_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(max3(STRETCH_CYC, LOCK_FILT, STEP_CYC) + 1);

    if (N_DOM < 1 || STRETCH_CYC < 1 || LOCK_FILT < 1 || STEP_CYC < 1 || WDT_W < 1) begin : g_param_check
        $error("soc_reset_sequencer: parameter out of range");
    end

    rst_state_e         state, state_nxt;
    logic [CNT_W-1:0]   tmr, tmr_nxt;
    logic [N_DOM-1:0]   rst_q, rst_nxt;
    logic [CAUSE_W-1:0] cause, cause_nxt, trig_bits;
    logic               trigger, lock_done, filt_clr, wdt_fire;

    assign filt_clr = (state != WAIT_LOCK);

    soc_rst_lock_filter #(.LOCK_FILT(LOCK_FILT)) u_lock_filter (
        .clk        (clk),
        .rst        (rst),
        .clr        (filt_clr),
        .pll_locked (bus.pll_locked),
        .done       (lock_done)
    );

`ifdef SOC_RST_WDT_EN
    logic [WDT_W-1:0] wdt_cnt;

    // A kick in the terminal-count cycle suppresses the fire.
    assign wdt_fire = (state == RUN) && !bus.wdt_kick && (&wdt_cnt);

    always_ff @(posedge clk) begin
        if (rst || state != RUN || bus.wdt_kick || trigger) begin
            wdt_cnt <= '0;
        end else if (bus.wdt_arm) begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    always_comb begin
        trig_bits             = '0;
        trig_bits[CAUSE_EXT]  = bus.ext_rst_req;
        trig_bits[CAUSE_SW]   = bus.sw_rst_req;
        trig_bits[CAUSE_LOCK] = (state == RELEASE || state == RUN) && !bus.pll_locked;
        trig_bits[CAUSE_WDT]  = wdt_fire;
    end

    assign trigger = |trig_bits;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt = state;
        tmr_nxt   = tmr;
        rst_nxt   = rst_q;
        cause_nxt = cause;
        if (trigger) begin
            state_nxt = ASSERT;
            tmr_nxt   = '0;
            rst_nxt   = '1;
            cause_nxt = (state == ASSERT) ? (cause | trig_bits) : trig_bits;
        end else begin
            if (bus.cause_clr) begin
                cause_nxt = '0;
            end
            unique case (state)
                ASSERT: begin
                    if (tmr == CNT_W'(STRETCH_CYC - 1)) begin
                        state_nxt = WAIT_LOCK;
                        tmr_nxt   = '0;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_done) begin
                        rst_nxt   = rst_q << 1;
                        tmr_nxt   = '0;
                        state_nxt = (rst_nxt == '0) ? RUN : RELEASE;
                    end
                end
                RELEASE: begin
                    // Domains release low index first by shifting the asserted mask up.
                    if (tmr == CNT_W'(STEP_CYC - 1)) begin
                        rst_nxt = rst_q << 1;
                        tmr_nxt = '0;
                        if (rst_nxt == '0) begin
                            state_nxt = RUN;
                        end
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                RUN: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
        if (rst) begin
            state <= ASSERT;
            tmr   <= '0;
            rst_q <= '1;
            cause <= CAUSE_RST_VAL;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            rst_q <= rst_nxt;
            cause <= cause_nxt;
        end
    end

    assign bus.rst_out   = rst_q;
    assign bus.seq_done  = (state == RUN);
    assign bus.rst_cause = cause;

endmodule
